dyna_packet_tx: RTL and testbench
=================================

DYNA_PACKET_TX -- requirements
Module: dyna_packet_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 50, meaning clock cycles per UART bit (1 Mbaud at 50 MHz).
REQ-002 SHALL have parameter MAX_PARAMS, default 4, meaning the maximum number of instruction parameter bytes.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request to send one packet; honoured only when idle.
REQ-006 SHALL have port id  input  8  Dynamixel servo ID.
REQ-007 SHALL have port instr  input  8  instruction code.
REQ-008 SHALL have port nparam  input  3  number of parameter bytes, 0..MAX_PARAMS.
REQ-009 SHALL have port params  input  MAX_PARAMS x 8  parameter bytes; params[0] is sent first.
REQ-010 SHALL have port tx  output  1  UART 8N1 serial line, LSB first, idle high.
REQ-011 SHALL have port tx_en  output  1  half-duplex buffer direction, 1 = drive bus.
REQ-012 SHALL have port busy  output  1  packet in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse at packet completion.

Function
REQ-014 SHALL emit Protocol 1.0 packet bytes in order: 0xFF, 0xFF, ID, LEN, INSTR, P0..P(N-1), CHK, with N = nparam.
REQ-015 SHALL compute LEN = N + 2 and CHK = bitwise NOT of low 8 bits of (ID + LEN + INSTR + sum of P), with modulo-256 accumulation.
REQ-016 SHALL treat nparam values above MAX_PARAMS as MAX_PARAMS.
REQ-017 SHALL register id, instr, nparam and params on the accepted start cycle; input changes during busy SHALL have no effect.
REQ-018 SHALL ignore start while busy = 1; no queuing.
REQ-019 SHALL raise busy and tx_en and drive the first start bit low the cycle after start is accepted.
REQ-020 SHALL hold each bit (start, d0..d7, stop) on tx for exactly CLKS_PER_BIT cycles, sending bytes back-to-back with no idle gap.
REQ-021 SHALL, after the final stop bit, keep tx high and tx_en = 1 for CLKS_PER_BIT further cycles (TURNAROUND).
REQ-022 SHALL pulse done for one cycle at TURNAROUND end, in the same cycle that busy and tx_en return to 0.
REQ-023 SHALL give a busy duration of (N+6)*10*CLKS_PER_BIT + CLKS_PER_BIT cycles.
REQ-024 SHALL implement FSM states IDLE -> SEND (per byte, byte index 0..N+5) -> TURNAROUND -> IDLE; SEND SHALL advance index on byte-complete and leave at index N+5.
REQ-025 SHALL accept a start asserted in the same cycle that done pulses only on the following cycle (IDLE).

Reset
REQ-026 SHALL, while reset_n = 0, force tx = 1, tx_en = 0, busy = 0, done = 0, FSM = IDLE and clear counters and checksum.
REQ-027 SHALL, on reset assertion mid-packet, abort immediately with no done pulse; the packet SHALL NOT resume after release.

Structure
REQ-028 SHALL take from shared package dyna_pkg: header 0xFF, instruction codes PING 0x01, READ 0x02, WRITE 0x03, and FSM state enum.
REQ-029 SHALL instantiate a single sub-module uart_tx_byte (byte load/ready handshake, CLKS_PER_BIT parameter, 8N1 serializer).

Verification
REQ-030 SHALL cover: WRITE id=0x01 instr=0x03 nparam=3 params=1E,00,02 -> bytes FF FF 01 05 03 1E 00 02 D6, busy 4550 cycles, one done pulse.
REQ-031 SHALL cover: PING id=0x01 instr=0x01 nparam=0 -> bytes FF FF 01 02 01 FB, busy 3050 cycles.
REQ-032 SHALL cover: nparam=7 with four params -> identical to nparam=4, LEN=0x06.
REQ-033 SHALL cover: start re-pulsed and inputs changed mid-packet -> output byte stream unchanged, single done.
REQ-034 SHALL cover: reset_n low during byte 3 -> tx=1, tx_en=0, busy=0 immediately, no done; next start sends a full correct packet.
REQ-035 SHALL cover: bit timing check -> every tx edge on CLKS_PER_BIT boundaries from the first start bit; tx_en covers the first start bit through the turnaround end.

Source files
------------

// File: rtl/dyna_pkg.sv
// Shared Dynamixel Protocol 1.0 constants and the packet transmitter state type.
package dyna_pkg;

    localparam logic [7:0] DYNA_HEADER = 8'hFF;
    localparam logic [7:0] INSTR_PING  = 8'h01;
    localparam logic [7:0] INSTR_READ  = 8'h02;
    localparam logic [7:0] INSTR_WRITE = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_TURN
    } dyna_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; ready is also high in the last stop-bit cycle so a new
// byte can be loaded back-to-back with no idle gap on the line.
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);

    logic          active_q, active_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    always_comb begin
        bit_end  = (cnt_q == CW'(CLKS_PER_BIT - 1));
        ready    = !active_q || (bit_q == 4'd9 && bit_end);
        active_d = active_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        if (load && ready) begin
            active_d = 1'b1;
            bit_d    = '0;
            cnt_d    = '0;
            tx_d     = 1'b0;
            shift_d  = {1'b1, data};
        end else if (active_q) begin
            if (bit_end) begin
                cnt_d = '0;
                if (bit_q == 4'd9) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    tx_d    = shift_q[0];
                    shift_d = {1'b1, shift_q[8:1]};
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            bit_q    <= '0;
            cnt_q    <= '0;
            shift_q  <= '1;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/dyna_packet_tx.sv
// Dynamixel Protocol 1.0 packet transmitter: header, ID, LEN, INSTR, params,
// checksum over a half-duplex UART, followed by one bit-time of bus turnaround.
module dyna_packet_tx
    import dyna_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 50,
    parameter int unsigned MAX_PARAMS   = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [7:0]                 id,
    input  logic [7:0]                 instr,
    input  logic [2:0]                 nparam,
    input  logic [MAX_PARAMS-1:0][7:0] params,
    output logic                       tx,
    output logic                       tx_en,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);

    dyna_state_e               state_q, state_d;
    logic [3:0]                idx_q, idx_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [7:0]                id_q, id_d, instr_q, instr_d, chk_q, chk_d;
    logic [2:0]                n_q, n_d;
    logic [MAX_PARAMS-1:0][7:0] params_q, params_d;
    logic                      busy_q, busy_d, tx_en_q, tx_en_d, done_q, done_d;

    logic [2:0] n_in;
    logic [7:0] sum, nxt_byte, load_data;
    logic [3:0] nxt_idx, last_idx;
    logic       load, ready;

    always_comb begin
        n_in = (nparam > 3'(MAX_PARAMS)) ? 3'(MAX_PARAMS) : nparam;
        sum  = id + instr + {5'd0, n_in} + 8'd2;
        for (int unsigned i = 0; i < MAX_PARAMS; i++)
            if (i < 32'(n_in)) sum = sum + params[i];

        // Byte for the next index; checksum overrides the param slot it may alias.
        last_idx = {1'b0, n_q} + 4'd5;
        nxt_idx  = idx_q + 4'd1;
        nxt_byte = DYNA_HEADER;
        for (int unsigned i = 0; i < MAX_PARAMS; i++)
            if (nxt_idx == 4'(i + 5)) nxt_byte = params_q[i];
        if (nxt_idx == 4'd2)      nxt_byte = id_q;
        else if (nxt_idx == 4'd3) nxt_byte = {5'd0, n_q} + 8'd2;
        else if (nxt_idx == 4'd4) nxt_byte = instr_q;
        if (nxt_idx == last_idx)  nxt_byte = chk_q;

        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        instr_d   = instr_q;
        chk_d     = chk_q;
        n_d       = n_q;
        params_d  = params_q;
        busy_d    = busy_q;
        tx_en_d   = tx_en_q;
        done_d    = 1'b0;
        load      = 1'b0;
        load_data = DYNA_HEADER;

        case (state_q)
            ST_IDLE: if (start) begin
                state_d  = ST_SEND;
                idx_d    = '0;
                id_d     = id;
                instr_d  = instr;
                n_d      = n_in;
                params_d = params;
                chk_d    = ~sum;
                busy_d   = 1'b1;
                tx_en_d  = 1'b1;
                load     = 1'b1;
            end
            ST_SEND: if (ready) begin
                if (idx_q == last_idx) begin
                    state_d = ST_TURN;
                    cnt_d   = '0;
                end else begin
                    idx_d     = nxt_idx;
                    load      = 1'b1;
                    load_data = nxt_byte;
                end
            end
            ST_TURN: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    tx_en_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            id_q     <= '0;
            instr_q  <= '0;
            chk_q    <= '0;
            n_q      <= '0;
            params_q <= '0;
            busy_q   <= 1'b0;
            tx_en_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            instr_q  <= instr_d;
            chk_q    <= chk_d;
            n_q      <= n_d;
            params_q <= params_d;
            busy_q   <= busy_d;
            tx_en_q  <= tx_en_d;
            done_q   <= done_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (load),
        .data   (load_data),
        .ready  (ready),
        .tx     (tx)
    );

    assign busy  = busy_q;
    assign tx_en = tx_en_q;
    assign done  = done_q;

endmodule

// File: tb/tb_dyna_packet_tx.sv
// Scoreboard bench for dyna_packet_tx: expected bytes and busy lengths are queued
// at stimulus time; UART and bus monitors pop and compare as the DUT emits them.
module tb_dyna_packet_tx;
    import dyna_pkg::*;

    localparam int CPB = 50;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [7:0]      id = '0, instr = '0;
    logic [2:0]      nparam = '0;
    logic [3:0][7:0] params = '0;
    logic            tx, tx_en, busy, done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];
    int         dur_q[$];

    always #5 clk = ~clk;

    dyna_packet_tx #(
        .CLKS_PER_BIT(CPB),
        .MAX_PARAMS  (4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .id     (id),
        .instr  (instr),
        .nparam (nparam),
        .params (params),
        .tx     (tx),
        .tx_en  (tx_en),
        .busy   (busy),
        .done   (done)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic exp(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic launch(input logic [7:0] i_id, input logic [7:0] i_ins, input logic [2:0] n,
                          input logic [7:0] p0, input logic [7:0] p1,
                          input logic [7:0] p2, input logic [7:0] p3);
        @(negedge clk);
        id = i_id; instr = i_ins; nparam = n;
        params[0] = p0; params[1] = p1; params[2] = p2; params[3] = p3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("accept_busy", int'(busy), 1);
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_timeout", int'(done), 1);
    endtask

    // UART receiver: samples mid-bit; a reset anywhere in the byte discards it.
    initial begin : rx_mon
        logic [7:0] b;
        bit ab;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && tx_en && tx == 1'b0) begin
                ab = 1'b0;
                repeat (CPB / 2 - 1) begin @(negedge clk); if (!reset_n) ab = 1'b1; end
                if (!ab) chk("start_bit", int'(tx), 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin @(negedge clk); if (!reset_n) ab = 1'b1; end
                    b[i] = tx;
                end
                repeat (CPB) begin @(negedge clk); if (!reset_n) ab = 1'b1; end
                if (!ab) begin
                    chk("stop_bit", int'(tx), 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", int'(b), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte", int'(b), int'(e));
                    end
                end
            end
        end
    end

    // Bus monitor: bit-edge alignment, tx_en framing, busy length, done placement.
    initial begin : bus_mon
        int   ncyc, t0, d;
        bit   in_pkt;
        logic tx_prev;
        ncyc = 0; t0 = 0; in_pkt = 1'b0; tx_prev = 1'b1;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!reset_n) begin
                in_pkt = 1'b0;
            end else begin
                if (busy && !in_pkt) begin
                    in_pkt = 1'b1;
                    t0 = ncyc;
                    chk("first_start_low", int'(tx), 0);
                end
                if (in_pkt && tx != tx_prev)
                    chk("bit_edge_phase", (ncyc - t0) % CPB, 0);
                chk("tx_en_vs_busy", int'(tx_en), int'(busy));
                if (done) done_cnt++;
                if (!busy && in_pkt) begin
                    in_pkt = 1'b0;
                    chk("done_at_end", int'(done), 1);
                    chk("tx_idle_at_end", int'(tx), 1);
                    if (dur_q.size() == 0) begin
                        chk("unexpected_packet", ncyc - t0, -1);
                    end else begin
                        d = dur_q.pop_front();
                        chk("busy_len", ncyc - t0, d);
                    end
                end else if (done) begin
                    chk("stray_done", int'(done), 0);
                end
            end
            tx_prev = tx;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin : stim
        int dc;
        repeat (3) @(negedge clk);
        chk("rst_tx", int'(tx), 1);
        chk("rst_tx_en", int'(tx_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // WRITE id 1: goal position params
        exp(8'hFF); exp(8'hFF); exp(8'h01); exp(8'h05); exp(8'h03);
        exp(8'h1E); exp(8'h00); exp(8'h02); exp(8'hD6);
        dur_q.push_back(4550);
        launch(8'h01, INSTR_WRITE, 3'd3, 8'h1E, 8'h00, 8'h02, 8'h00);
        wait_done(6000);
        @(negedge clk);
        chk("write_drained", exp_q.size(), 0);
        chk("write_done_cnt", done_cnt, 1);

        // PING id 1
        exp(8'hFF); exp(8'hFF); exp(8'h01); exp(8'h02); exp(8'h01); exp(8'hFB);
        dur_q.push_back(3050);
        launch(8'h01, INSTR_PING, 3'd0, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
        wait_done(6000);
        @(negedge clk);
        chk("ping_drained", exp_q.size(), 0);

        // nparam 7 clamps to 4
        exp(8'hFF); exp(8'hFF); exp(8'h05); exp(8'h06); exp(8'h03);
        exp(8'h10); exp(8'h20); exp(8'h30); exp(8'h40); exp(8'h51);
        dur_q.push_back(5050);
        launch(8'h05, INSTR_WRITE, 3'd7, 8'h10, 8'h20, 8'h30, 8'h40);
        wait_done(6000);
        @(negedge clk);
        chk("clamp_drained", exp_q.size(), 0);

        // READ with start re-pulsed and inputs scrambled while busy
        exp(8'hFF); exp(8'hFF); exp(8'h02); exp(8'h04); exp(8'h02);
        exp(8'h2B); exp(8'h01); exp(8'hCB);
        dur_q.push_back(4050);
        dc = done_cnt;
        launch(8'h02, INSTR_READ, 3'd2, 8'h2B, 8'h01, 8'h00, 8'h00);
        for (int r = 0; r < 4; r++) begin
            repeat (700) @(negedge clk);
            id = 8'h33 + 8'(r); instr = 8'h7F; nparam = 3'(r);
            params[0] = 8'h99; params[1] = 8'h88;
            start = 1'b1;
            repeat (3) @(negedge clk);
            start = 1'b0;
        end
        wait_done(6000);
        @(negedge clk);
        chk("midchg_drained", exp_q.size(), 0);
        chk("midchg_single_done", done_cnt, dc + 1);
        repeat (20) @(negedge clk);
        chk("midchg_no_restart", int'(busy), 0);

        // reset asserted during byte 3
        exp(8'hFF); exp(8'hFF); exp(8'h01);
        dc = done_cnt;
        launch(8'h01, INSTR_WRITE, 3'd3, 8'h1E, 8'h00, 8'h02, 8'h00);
        repeat (1700) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_tx", int'(tx), 1);
        chk("abort_tx_en", int'(tx_en), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        repeat (20) @(negedge clk);
        reset_n = 1'b1;
        repeat (600) @(negedge clk);
        chk("abort_no_resume", int'(busy), 0);
        chk("abort_tx_idle", int'(tx), 1);
        chk("abort_no_done", done_cnt, dc);
        chk("abort_drained", exp_q.size(), 0);

        // full packet after the abort, then a start held in the done cycle
        exp(8'hFF); exp(8'hFF); exp(8'h01); exp(8'h02); exp(8'h01); exp(8'hFB);
        dur_q.push_back(3050);
        launch(8'h01, INSTR_PING, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_done(6000);
        exp(8'hFF); exp(8'hFF); exp(8'hFE); exp(8'h02); exp(8'h01); exp(8'hFE);
        dur_q.push_back(3050);
        id = 8'hFE; instr = INSTR_PING; nparam = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accept", int'(busy), 1);
        wait_done(6000);
        @(negedge clk);
        chk("b2b_drained", exp_q.size(), 0);

        repeat (10) @(negedge clk);
        chk("total_done", done_cnt, 6);
        chk("dur_drained", dur_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
